alu_issue_sched: RTL and testbench

// - Issue scheduler for the shared ALU. Arbitrates among NREQ ALU reservation-station slices, each presenting one ready entry.
// - Picks the oldest entry by inst_num and registers it into a one-deep issue stage toward the ALU.
// - Exerts valid/ready backpressure on the requesters and flushes on exception_sig or mret_sig.

---
 rtl/alu_issue_sched.sv | 164 ++++++++++++++++
 tb/tb_alu_issue_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_sched.sv
// ---------------------------------------------------------------------------
// alu_issue_sched
//
// Issue scheduler for the shared ALU. NREQ reservation-station slices each
// present at most one ready entry. The oldest entry is chosen by inst_num,
// using wrap-safe 32-bit ordering. The chosen entry is loaded into a one-deep
// issue stage that feeds the ALU.
//
// Handshake (valid/ready): the stage accepts a new entry when at least one req
// is high, the stage is empty or the ALU is taking the current packet
// (alu_ready), and no flush is active. An accepted entry is signalled by a
// one-hot grant in the same cycle. The requester must drop or replace that
// entry in the following cycle. The issued packet is held, with all issue
// outputs stable, while issue_valid=1 and alu_ready=0.
//
// Optional build macro: ISSUE_STARVE_GUARD_EN
//   When defined, each requester has a saturating wait counter. A requester
//   whose counter reaches STARVE_LIMIT wins ahead of age order; if several
//   are starved, the lowest index wins. When the macro is undefined, no
//   counters exist and selection is purely oldest-first.
//
// Ports
//   clk            : rising-edge clock
//   reset          : asynchronous, active-high; clears all state
//   exception_sig  : synchronous flush
//   mret_sig       : synchronous flush
//   req            : requester i holds a ready entry
//   req_inst_num   : inst_num of requester i, packed {i=NREQ-1..0}
//   req_payload    : packet of requester i, packed {i=NREQ-1..0}
//   grant          : one-hot; entry of requester i is consumed this cycle
//   issue_valid    : issue stage holds a packet (also the stage FSM state)
//   issue_inst_num : inst_num of the issued packet
//   issue_payload  : packet to the ALU
//   issue_src      : index of the winning requester
//   alu_ready      : ALU accepts the issued packet this cycle
// ---------------------------------------------------------------------------
module alu_issue_sched #(
    parameter int NREQ         = 4,
    parameter int PW           = 127,
    parameter int STARVE_LIMIT = 15,
    localparam int SW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 exception_sig,
    input  logic                 mret_sig,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   req_inst_num,
    input  logic [NREQ*PW-1:0]   req_payload,
    output logic [NREQ-1:0]      grant,
    output logic                 issue_valid,
    output logic [31:0]          issue_inst_num,
    output logic [PW-1:0]        issue_payload,
    output logic [SW-1:0]        issue_src,
    input  logic                 alu_ready
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    if (NREQ < 2 || NREQ > 8 || STARVE_LIMIT < 1) begin : g_param_check
        $error("alu_issue_sched: NREQ must be 2..8 and STARVE_LIMIT >= 1");
    end

    logic [0:0]      r_state;
    logic [31:0]     r_inst_num;
    logic [PW-1:0]   r_payload;
    logic [SW-1:0]   r_src;

    logic            w_flush;
    logic            w_accept;
    logic [NREQ-1:0] w_starved;
    logic            w_found;
    logic            w_best_starved;
    logic [SW-1:0]   w_win;
    logic [31:0]     w_best_inst;
    logic [31:0]     w_diff;

    assign w_flush  = exception_sig | mret_sig;
    // Reset gating keeps grant low while reset is held, even if req is high.
    assign w_accept = (|req) && ((r_state == ST_EMPTY) || alu_ready) && !w_flush && !reset;

`ifdef ISSUE_STARVE_GUARD_EN
    localparam int CW = ($clog2(STARVE_LIMIT + 1) > 4) ? $clog2(STARVE_LIMIT + 1) : 4;
    logic [CW-1:0] r_wait [NREQ];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) r_wait[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_flush || !req[i] || grant[i]) begin
                    r_wait[i] <= '0;
                end else if (r_wait[i] != CW'(STARVE_LIMIT)) begin
                    r_wait[i] <= r_wait[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_starved = '0;
        for (int i = 0; i < NREQ; i++) w_starved[i] = (r_wait[i] == CW'(STARVE_LIMIT));
    end
`else
    assign w_starved = '0;
`endif

    // Linear scan in index order. A later requester replaces the current
    // best only when it is strictly better, so ties go to the lowest index.
    // A starved requester beats any non-starved one. Two starved requesters
    // never replace each other, so the lowest starved index wins.
    always_comb begin
        w_found        = 1'b0;
        w_best_starved = 1'b0;
        w_win          = '0;
        w_best_inst    = '0;
        w_diff         = '0;
        for (int i = 0; i < NREQ; i++) begin
            // Wrap-safe age compare: candidate older when (cand - best) < 0.
            w_diff = req_inst_num[i*32 +: 32] - w_best_inst;
            if (req[i]) begin
                if (!w_found
                    || (w_starved[i] && !w_best_starved)
                    || (!w_starved[i] && !w_best_starved && w_diff[31])) begin
                    w_found        = 1'b1;
                    w_win          = SW'(i);
                    w_best_inst    = req_inst_num[i*32 +: 32];
                    w_best_starved = w_starved[i];
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++) grant[i] = w_accept && (w_win == SW'(i));
    end

    // Stage FSM. Flush has priority, then a new accept, then draining.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_inst_num <= '0;
            r_payload  <= '0;
            r_src      <= '0;
        end else if (w_flush) begin
            r_state <= ST_EMPTY;
        end else if (w_accept) begin
            r_state    <= ST_FULL;
            r_inst_num <= w_best_inst;
            r_payload  <= req_payload[w_win*PW +: PW];
            r_src      <= w_win;
        end else if (r_state == ST_FULL && alu_ready) begin
            r_state <= ST_EMPTY;
        end
    end

    assign issue_valid    = (r_state == ST_FULL);
    assign issue_inst_num = r_inst_num;
    assign issue_payload  = r_payload;
    assign issue_src      = r_src;

endmodule

// File: tb/tb_alu_issue_sched.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_sched
//
// Directed bench for alu_issue_sched (NREQ=4, PW=127, STARVE_LIMIT=3).
// A table of single-cycle arbitration vectors is followed by hand-written
// sequences for the following cases:
//   - backpressure
//   - flush, using exception_sig and mret_sig
//   - reset asserted while a packet is held
//   - starvation
// The expected starvation outcome depends on ISSUE_STARVE_GUARD_EN.
// ---------------------------------------------------------------------------
module tb_alu_issue_sched;

    localparam int NREQ = 4;
    localparam int PW   = 127;
    localparam int SL   = 3;

    logic                clk = 1'b0;
    logic                reset;
    logic                exception_sig;
    logic                mret_sig;
    logic [NREQ-1:0]     req;
    logic [NREQ*32-1:0]  req_inst_num;
    logic [NREQ*PW-1:0]  req_payload;
    logic [NREQ-1:0]     grant;
    logic                issue_valid;
    logic [31:0]         issue_inst_num;
    logic [PW-1:0]       issue_payload;
    logic [1:0]          issue_src;
    logic                alu_ready;

    logic [31:0]         inst_arr [NREQ];

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [3:0]  req;
        logic [31:0] i3, i2, i1, i0;
        logic [3:0]  exp_grant;
        logic [1:0]  exp_src;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vt [11];

    alu_issue_sched #(.NREQ(NREQ), .PW(PW), .STARVE_LIMIT(SL)) dut (
        .clk            (clk),
        .reset          (reset),
        .exception_sig  (exception_sig),
        .mret_sig       (mret_sig),
        .req            (req),
        .req_inst_num   (req_inst_num),
        .req_payload    (req_payload),
        .grant          (grant),
        .issue_valid    (issue_valid),
        .issue_inst_num (issue_inst_num),
        .issue_payload  (issue_payload),
        .issue_src      (issue_src),
        .alu_ready      (alu_ready)
    );

    // Clock and reset.
    always #5 clk = ~clk;

    // Each requester's payload is a distinct function of its index and inst.
    function automatic logic [PW-1:0] pay_of(input int idx, input logic [31:0] inst);
        logic [7:0] tag;
        tag = 8'hC0 + 8'(idx);
        return {87'd0, tag, inst};
    endfunction

    always_comb begin
        req_inst_num = '0;
        req_payload  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_inst_num[i*32 +: 32] = inst_arr[i];
            req_payload[i*PW +: PW]  = pay_of(i, inst_arr[i]);
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to one time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_insts(input logic [31:0] a3, input logic [31:0] a2,
                             input logic [31:0] a1, input logic [31:0] a0);
        inst_arr[3] = a3;
        inst_arr[2] = a2;
        inst_arr[1] = a1;
        inst_arr[0] = a0;
    endtask

    initial begin
        logic [31:0] e_inst;
        logic [3:0]  e_grant;
        logic [1:0]  e_src;

        reset         = 1'b1;
        exception_sig = 1'b0;
        mret_sig      = 1'b0;
        alu_ready     = 1'b1;
        req           = 4'b1111;
        set_insts(32'd4, 32'd3, 32'd2, 32'd1);

        // Reset state. No grant may appear while reset is held.
        tick();
        chk("reset_valid",   128'(issue_valid), 128'd0);
        chk("reset_inst",    128'(issue_inst_num), 128'd0);
        chk("reset_payload", 128'(issue_payload), 128'd0);
        chk("reset_src",     128'(issue_src), 128'd0);
        chk("reset_grant",   128'(grant), 128'd0);
        reset = 1'b0;
        req   = 4'b0000;
        tick();

        // Arbitration table: {req, i3, i2, i1, i0, grant, src, inst}.
        vt[0]  = '{4'b0001, 32'd0, 32'd0, 32'd0, 32'd5, 4'b0001, 2'd0, 32'd5};
        vt[1]  = '{4'b1111, 32'd40, 32'd12, 32'd30, 32'd12, 4'b0001, 2'd0, 32'd12};
        vt[2]  = '{4'b1110, 32'd40, 32'd12, 32'd30, 32'd12, 4'b0100, 2'd2, 32'd12};
        vt[3]  = '{4'b0011, 32'd0, 32'd0, 32'h0000_0003, 32'hFFFF_FFFE, 4'b0001, 2'd0, 32'hFFFF_FFFE};
        vt[4]  = '{4'b1000, 32'd7, 32'd0, 32'd0, 32'd0, 4'b1000, 2'd3, 32'd7};
        vt[5]  = '{4'b0110, 32'd0, 32'd50, 32'd20, 32'd0, 4'b0010, 2'd1, 32'd20};
        vt[6]  = '{4'b1010, 32'd9, 32'd0, 32'd10, 32'd0, 4'b1000, 2'd3, 32'd9};
        vt[7]  = '{4'b0000, 32'd1, 32'd2, 32'd3, 32'd4, 4'b0000, 2'd0, 32'd0};
        vt[8]  = '{4'b1100, 32'h8000_0000, 32'h7FFF_FFFF, 32'd0, 32'd0, 4'b0100, 2'd2, 32'h7FFF_FFFF};
        vt[9]  = '{4'b1111, 32'd77, 32'd77, 32'd77, 32'd77, 4'b0001, 2'd0, 32'd77};
        vt[10] = '{4'b0101, 32'd0, 32'd3, 32'd0, 32'd4, 4'b0100, 2'd2, 32'd3};

        for (int v = 0; v < 11; v++) begin
            // One idle cycle drains the stage and clears any wait counters.
            req = 4'b0000;
            tick();
            chk($sformatf("v%0d_drained", v), 128'(issue_valid), 128'd0);
            set_insts(vt[v].i3, vt[v].i2, vt[v].i1, vt[v].i0);
            req = vt[v].req;
            #2;
            chk($sformatf("v%0d_grant", v), 128'(grant), 128'(vt[v].exp_grant));
            if (vt[v].exp_grant != 4'b0000) exp_q.push_back(vt[v].exp_inst);
            tick();
            chk($sformatf("v%0d_valid", v), 128'(issue_valid), 128'(vt[v].exp_grant != 4'b0000));
            if (vt[v].exp_grant != 4'b0000) begin
                e_inst = exp_q.pop_front();
                chk($sformatf("v%0d_src", v), 128'(issue_src), 128'(vt[v].exp_src));
                chk($sformatf("v%0d_inst", v), 128'(issue_inst_num), 128'(e_inst));
                chk($sformatf("v%0d_payload", v), 128'(issue_payload),
                    128'(pay_of(int'(vt[v].exp_src), e_inst)));
            end
        end

        // Backpressure: the packet is held for three cycles, then replaced.
        req = 4'b0000;
        tick();
        set_insts(32'd0, 32'd0, 32'd0, 32'd5);
        req       = 4'b0001;
        alu_ready = 1'b1;
        tick();
        chk("bp_load_valid", 128'(issue_valid), 128'd1);
        req         = 4'b0010;
        inst_arr[1] = 32'd9;
        alu_ready   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            chk($sformatf("bp_hold%0d_grant", c), 128'(grant), 128'd0);
            tick();
            chk($sformatf("bp_hold%0d_valid", c), 128'(issue_valid), 128'd1);
            chk($sformatf("bp_hold%0d_src", c), 128'(issue_src), 128'd0);
            chk($sformatf("bp_hold%0d_inst", c), 128'(issue_inst_num), 128'd5);
        end
        alu_ready = 1'b1;
        #2;
        chk("bp_release_grant", 128'(grant), 128'b0010);
        tick();
        chk("bp_next_valid", 128'(issue_valid), 128'd1);
        chk("bp_next_src", 128'(issue_src), 128'd1);
        chk("bp_next_inst", 128'(issue_inst_num), 128'd9);
        req = 4'b0000;
        tick();
        chk("bp_drain_valid", 128'(issue_valid), 128'd0);

        // Flush via exception_sig while full, with alu_ready low.
        req = 4'b0001;
        tick();
        chk("exc_load_valid", 128'(issue_valid), 128'd1);
        req           = 4'b0011;
        exception_sig = 1'b1;
        alu_ready     = 1'b0;
        #2;
        chk("exc_grant", 128'(grant), 128'd0);
        tick();
        chk("exc_valid", 128'(issue_valid), 128'd0);
        exception_sig = 1'b0;

        // Flush via mret_sig while full; alu_ready is ignored in the flush cycle.
        req       = 4'b0001;
        alu_ready = 1'b1;
        tick();
        chk("mret_load_valid", 128'(issue_valid), 128'd1);
        req      = 4'b0011;
        mret_sig = 1'b1;
        #2;
        chk("mret_grant", 128'(grant), 128'd0);
        tick();
        chk("mret_valid", 128'(issue_valid), 128'd0);
        mret_sig = 1'b0;

        // Flush on an empty stage: the entry is not consumed.
        exception_sig = 1'b1;
        #2;
        chk("exc_empty_grant", 128'(grant), 128'd0);
        tick();
        chk("exc_empty_valid", 128'(issue_valid), 128'd0);
        exception_sig = 1'b0;

        // Reset asserted while a packet is held: it is dropped at once.
        req       = 4'b0001;
        alu_ready = 1'b1;
        tick();
        chk("rst_load_valid", 128'(issue_valid), 128'd1);
        alu_ready = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("rst_async_valid", 128'(issue_valid), 128'd0);
        chk("rst_async_inst", 128'(issue_inst_num), 128'd0);
        chk("rst_async_grant", 128'(grant), 128'd0);
        tick();
        chk("rst_held_valid", 128'(issue_valid), 128'd0);
        reset = 1'b0;
        #2;
        chk("rst_after_grant", 128'(grant), 128'b0001);
        tick();
        chk("rst_after_valid", 128'(issue_valid), 128'd1);
        chk("rst_after_inst", 128'(issue_inst_num), 128'd5);
        req       = 4'b0000;
        alu_ready = 1'b1;
        tick();

        // Starvation: req3 (inst 100) waits while an older stream runs on req0.
        set_insts(32'd100, 32'd0, 32'd0, 32'd1);
        req = 4'b1001;
        for (int c = 0; c < 6; c++) begin
            inst_arr[0] = 32'(c + 1);
`ifdef ISSUE_STARVE_GUARD_EN
            e_grant = (c == 3) ? 4'b1000 : 4'b0001;
`else
            e_grant = 4'b0001;
`endif
            e_src = (e_grant == 4'b1000) ? 2'd3 : 2'd0;
            #2;
            chk($sformatf("starve%0d_grant", c), 128'(grant), 128'(e_grant));
            tick();
            chk($sformatf("starve%0d_src", c), 128'(issue_src), 128'(e_src));
        end
        req = 4'b0000;
        tick();
        chk("final_drain_valid", 128'(issue_valid), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
